// File: rtl/mimo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// mimo_frame_ctrl : per-frame sequencer (loader start, H/Y gating, QR/detector handshakes)
// Rev 1.0
// ============================================================================
module mimo_frame_ctrl #(
  parameter int N     = 32,
  parameter int H_LEN = 16,
  parameter int Y_LEN = 8,
  parameter int G_LEN = 4,
  parameter int TO_W  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_req,
  output logic         frame_ack,
  input  logic         h_s_valid,
  output logic         h_s_ready,
  input  logic [N-1:0] h_s_r,
  input  logic [N-1:0] h_s_i,
  input  logic         y_s_valid,
  output logic         y_s_ready,
  input  logic [N-1:0] y_s_r,
  input  logic [N-1:0] y_s_i,
  output logic         ld_start,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         hq_done,
  output logic         g_valid,
  input  logic         det_done,
  output logic         busy,
  output logic         frame_done,
  output logic         timeout_err,
  output logic [15:0]  frame_cnt
);

  localparam int HW = $clog2(H_LEN + 1);
  localparam int YW = $clog2(Y_LEN + 1);
  localparam int GW = (G_LEN > 1) ? $clog2(G_LEN) : 1;

  localparam logic [HW-1:0]   C_H_LAST  = HW'(H_LEN - 1);
  localparam logic [YW-1:0]   C_Y_ALL   = YW'(Y_LEN);
  localparam logic [GW-1:0]   C_G_LAST  = GW'(G_LEN - 1);
  localparam logic [TO_W-1:0] C_TMO_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT_HQ  = 3'd3,
    S_FEED_G   = 3'd4,
    S_WAIT_DET = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [YW-1:0]     y_cnt_q, y_cnt_d;
  logic [GW-1:0]     g_cnt_q, g_cnt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic w_in_load;
  logic w_h_fire;
  logic w_y_fire;

  // The final H sample is held back until every Y sample has been accepted,
  // so the loader always sees the complete Y set before H is closed out.
  assign w_in_load = (state_q == S_LOAD);
  assign y_s_ready = w_in_load && (y_cnt_q < C_Y_ALL);
  assign h_s_ready = w_in_load &&
                     ((h_cnt_q < C_H_LAST) || ((h_cnt_q == C_H_LAST) && (y_cnt_q == C_Y_ALL)));

  assign w_h_fire   = h_s_valid && h_s_ready;
  assign w_y_fire   = y_s_valid && y_s_ready;
  assign H_in_valid = w_h_fire;
  assign Y_in_valid = w_y_fire;
  assign H_in_r     = h_s_r;
  assign H_in_i     = h_s_i;
  assign Y_in_r     = y_s_r;
  assign Y_in_i     = y_s_i;

  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    y_cnt_d     = y_cnt_q;
    g_cnt_d     = '0;
    tmo_d       = '0;
    frame_cnt_d = frame_cnt_q;
    frame_ack   = 1'b0;
    ld_start    = 1'b0;
    g_valid     = 1'b0;
    frame_done  = 1'b0;
    timeout_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_req && !rst) begin
          frame_ack = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        ld_start = 1'b1;
        h_cnt_d  = '0;
        y_cnt_d  = '0;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        if (w_h_fire) h_cnt_d = h_cnt_q + 1'b1;
        if (w_y_fire) y_cnt_d = y_cnt_q + 1'b1;
        if (w_h_fire && (h_cnt_q == C_H_LAST)) state_d = S_WAIT_HQ;
      end
      S_WAIT_HQ: begin
        tmo_d = tmo_q + 1'b1;
        // A completion arriving on the terminal count still counts as success.
        if (hq_done) begin
          state_d = S_FEED_G;
        end else if (tmo_q == C_TMO_MAX) begin
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_FEED_G: begin
        g_valid = 1'b1;
        g_cnt_d = g_cnt_q + 1'b1;
        if (g_cnt_q == C_G_LAST) state_d = S_WAIT_DET;
      end
      S_WAIT_DET: begin
        tmo_d = tmo_q + 1'b1;
        if (det_done) begin
          state_d = S_DONE;
        end else if (tmo_q == C_TMO_MAX) begin
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      y_cnt_q     <= '0;
      g_cnt_q     <= '0;
      tmo_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      y_cnt_q     <= y_cnt_d;
      g_cnt_q     <= g_cnt_d;
      tmo_q       <= tmo_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mimo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mimo_frame_ctrl : frame-timeline checker for mimo_frame_ctrl
// Rev 1.0
// ============================================================================
module tb_mimo_frame_ctrl;

  localparam int N       = 32;
  localparam int TMO_CYC = 1 << 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_req;
  logic          frame_ack;
  logic          h_s_valid, h_s_ready;
  logic [N-1:0]  h_s_r, h_s_i;
  logic          y_s_valid, y_s_ready;
  logic [N-1:0]  y_s_r, y_s_i;
  logic          ld_start;
  logic          H_in_valid;
  logic [N-1:0]  H_in_r, H_in_i;
  logic          Y_in_valid;
  logic [N-1:0]  Y_in_r, Y_in_i;
  logic          hq_done;
  logic          g_valid;
  logic          det_done;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  mimo_frame_ctrl #(.N(N), .H_LEN(16), .Y_LEN(8), .G_LEN(4), .TO_W(10)) dut (
    .clk(clk), .rst(rst),
    .frame_req(frame_req), .frame_ack(frame_ack),
    .h_s_valid(h_s_valid), .h_s_ready(h_s_ready), .h_s_r(h_s_r), .h_s_i(h_s_i),
    .y_s_valid(y_s_valid), .y_s_ready(y_s_ready), .y_s_r(y_s_r), .y_s_i(y_s_i),
    .ld_start(ld_start),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .hq_done(hq_done), .g_valid(g_valid), .det_done(det_done),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  // One frame scenario: stimulus knobs followed by expected per-frame totals.
  // hq_wait/det_wait = cycle (1-based) of the WAIT phase on which done is
  // raised, 0 = never. rst_g = FEED_G cycle on which rst is applied, 0 = none.
  typedef struct {
    int hq_wait; int det_wait; int h_gap; int y_gap; int y_delay; int rst_g;
    int exp_h; int exp_y; int exp_g; int exp_done; int exp_tmo; int exp_lat;
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int h_n, y_n, g_n, done_n, tmo_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon();
    h_n    += int'(H_in_valid);
    y_n    += int'(Y_in_valid);
    g_n    += int'(g_valid);
    done_n += int'(frame_done);
    tmo_n  += int'(timeout_err);
  endtask

  task automatic rand_noise();
    h_s_valid = 1'($urandom_range(1));
    y_s_valid = 1'($urandom_range(1));
    h_s_r = $urandom; h_s_i = $urandom;
    y_s_r = $urandom; y_s_i = $urandom;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    rand_noise(); hq_done = 1'b0; det_done = 1'b0;
    #1; mon();
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
  endtask

  // Drives a complete frame and checks it against the timeline implied by the
  // handshake rules; returns after the frame has ended (done, timeout or reset).
  task automatic run_frame(input vec_t v, input string tag);
    int cyc, hs, ys, k, w;
    bit er_h, er_y, fin, rst_hit;
    h_n = 0; y_n = 0; g_n = 0; done_n = 0; tmo_n = 0;
    rst_hit = 1'b0;

    @(negedge clk);
    frame_req = 1'b1; rand_noise(); hq_done = 1'($urandom_range(1)); det_done = 1'($urandom_range(1));
    #1; mon(); cyc = 1;
    chk({tag, "_ack"}, 32'(frame_ack), 32'd1);
    chk({tag, "_busy_req"}, 32'(busy), 32'd0);

    @(negedge clk);
    frame_req = 1'b0; rand_noise();
    #1; mon(); cyc++;
    chk({tag, "_ld_start"}, 32'(ld_start), 32'd1);
    chk({tag, "_rdy_start"}, 32'({h_s_ready, y_s_ready}), 32'd0);
    chk({tag, "_ack_start"}, 32'(frame_ack), 32'd0);

    hs = 0; ys = 0; k = 0;
    while (hs < 16 && k < 4000) begin
      @(negedge clk);
      hq_done = 1'b0; det_done = 1'b0;
      h_s_valid = (hs < 16) && (int'($urandom_range(99)) >= v.h_gap);
      y_s_valid = (ys < 8) && (k >= v.y_delay) && (int'($urandom_range(99)) >= v.y_gap);
      h_s_r = $urandom; h_s_i = $urandom; y_s_r = $urandom; y_s_i = $urandom;
      #1; mon(); cyc++;
      er_h = (hs < 15) || (hs == 15 && ys == 8);
      er_y = (ys < 8);
      chk({tag, "_h_ready"}, 32'(h_s_ready), 32'(er_h));
      chk({tag, "_y_ready"}, 32'(y_s_ready), 32'(er_y));
      chk({tag, "_H_valid"}, 32'(H_in_valid), 32'(h_s_valid && er_h));
      chk({tag, "_Y_valid"}, 32'(Y_in_valid), 32'(y_s_valid && er_y));
      chk({tag, "_H_data"}, H_in_r ^ H_in_i, h_s_r ^ h_s_i);
      chk({tag, "_Y_data"}, Y_in_r ^ Y_in_i, y_s_r ^ y_s_i);
      chk({tag, "_load_misc"}, 32'({ld_start, g_valid, busy}), 32'b001);
      if (h_s_valid && er_h) hs++;
      if (y_s_valid && er_y) ys++;
      k++;
    end
    chk({tag, "_load_bound"}, 32'(hs), 32'd16);

    fin = 1'b0; w = 0;
    while (!fin && w < TMO_CYC + 8) begin
      @(negedge clk);
      rand_noise(); w++;
      hq_done = (v.hq_wait == w); det_done = 1'($urandom_range(1));
      #1; mon(); cyc++;
      chk({tag, "_hq_rdy"}, 32'({h_s_ready, y_s_ready, g_valid}), 32'd0);
      chk({tag, "_hq_tmo"}, 32'(timeout_err), 32'(w == TMO_CYC && v.hq_wait != w));
      if (hq_done || w == TMO_CYC) fin = 1'b1;
    end

    if (v.hq_wait == 0) begin
      idle_check({tag, "_post_hq_tmo"});
    end else begin
      for (int g = 1; g <= 4 && !rst_hit; g++) begin
        @(negedge clk);
        rand_noise(); hq_done = 1'($urandom_range(1)); det_done = 1'($urandom_range(1));
        if (v.rst_g == g) begin rst = 1'b1; rst_hit = 1'b1; end
        #1; mon(); cyc++;
        chk({tag, "_g_valid"}, 32'({g_valid, busy}), 32'b11);
      end
      if (rst_hit) begin
        @(negedge clk);
        rst = 1'b0; rand_noise(); hq_done = 1'b0; det_done = 1'b0;
        #1; mon();
        exp_cnt = 0;
        chk({tag, "_rst_state"}, 32'({g_valid, busy}), 32'd0);
        chk({tag, "_rst_cnt"}, 32'(frame_cnt), 32'd0);
      end else begin
        fin = 1'b0; w = 0;
        while (!fin && w < TMO_CYC + 8) begin
          @(negedge clk);
          rand_noise(); w++;
          det_done = (v.det_wait == w); hq_done = 1'($urandom_range(1));
          #1; mon(); cyc++;
          chk({tag, "_det_rdy"}, 32'({h_s_ready, y_s_ready, g_valid, frame_done}), 32'd0);
          chk({tag, "_det_tmo"}, 32'(timeout_err), 32'(w == TMO_CYC && v.det_wait != w));
          if (det_done || w == TMO_CYC) fin = 1'b1;
        end
        if (v.det_wait == 0) begin
          idle_check({tag, "_post_det_tmo"});
        end else begin
          @(negedge clk);
          rand_noise(); det_done = 1'b0; hq_done = 1'($urandom_range(1));
          #1; mon(); cyc++;
          chk({tag, "_done"}, 32'(frame_done), 32'd1);
          chk({tag, "_cnt_in_done"}, 32'(frame_cnt), 32'(exp_cnt));
          if (v.exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
          exp_cnt = (exp_cnt + 1) & 16'hFFFF;
          idle_check({tag, "_post_done"});
        end
      end
    end

    chk({tag, "_n_h"}, 32'(h_n), 32'(v.exp_h));
    chk({tag, "_n_y"}, 32'(y_n), 32'(v.exp_y));
    chk({tag, "_n_g"}, 32'(g_n), 32'(v.exp_g));
    chk({tag, "_n_done"}, 32'(done_n), 32'(v.exp_done));
    chk({tag, "_n_tmo"}, 32'(tmo_n), 32'(v.exp_tmo));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    //           hq    det  hg yg yd rg  h  y  g dn to lat
    vecs[0] = '{    5,    3, 0, 0, 0, 0, 16, 8, 4, 1, 0, 31};   // nominal back-to-back
    vecs[1] = '{    2,    2, 0, 0,20, 0, 16, 8, 4, 1, 0, 40};   // Y arrives late
    vecs[2] = '{    1,    1, 0, 0, 0, 0, 16, 8, 4, 1, 0, 25};   // minimum waits
    vecs[3] = '{    0,    1, 0, 0, 0, 0, 16, 8, 0, 0, 1, -1};   // hq never arrives
    vecs[4] = '{ 1024,    2, 0, 0, 0, 0, 16, 8, 4, 1, 0, 1049}; // hq_done on terminal count
    vecs[5] = '{    3,    0,30,30, 0, 0, 16, 8, 4, 0, 1, -1};   // det never arrives
    vecs[6] = '{    1, 1024, 0, 0, 0, 0, 16, 8, 4, 1, 0, 1048}; // det_done on terminal count
    vecs[7] = '{    2,    2, 0, 0, 0, 2, 16, 8, 2, 0, 0, -1};   // rst in FEED_G cycle 2

    rst = 1'b1; frame_req = 1'b0; hq_done = 1'b0; det_done = 1'b0;
    h_s_valid = 1'b0; y_s_valid = 1'b0;
    h_s_r = '0; h_s_i = '0; y_s_r = '0; y_s_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset_ctrl", 32'({frame_ack, h_s_ready, y_s_ready, ld_start, H_in_valid, Y_in_valid}), 32'd0);
    chk("reset_stat", 32'({g_valid, busy, frame_done, timeout_err}), 32'd0);
    chk("reset_cnt", 32'(frame_cnt), 32'd0);

    // Stray completion pulses while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hq_done = 1'b1; det_done = 1'b1; rand_noise();
      #1;
      chk("idle_stray", 32'({busy, H_in_valid, Y_in_valid, g_valid, frame_done}), 32'd0);
    end
    hq_done = 1'b0; det_done = 1'b0;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    for (int f = 0; f < 50; f++) begin
      rv = '{int'($urandom_range(8, 1)), int'($urandom_range(8, 1)),
             int'($urandom_range(60)), int'($urandom_range(60)), int'($urandom_range(10)), 0,
             16, 8, 4, 1, 0, -1};
      run_frame(rv, $sformatf("rnd%0d", f));
    end
    chk("frame_cnt_50", 32'(frame_cnt), 32'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
